// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       neg,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegMinus = 7'h3F;
    localparam logic [6:0] SegErr   = 7'h06;

    // Buffer layout: {neg, hundreds, tens, ones}
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [12:0]     stg_q, stg_d;
    logic [12:0]     disp_q, disp_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_q;

    logic            tc;
    logic            boundary;
    logic [12:0]     load_val;
    logic            disp_neg;
    logic [3:0]      disp_h, disp_t, disp_o;
    logic            blank_h, blank_t;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SegErr;
        endcase
        return code;
    endfunction

    assign tc       = (cnt_q == CntMax);
    assign boundary = tc && (idx_q == 2'd3);
    assign load_val = {neg, bcd2, bcd1, bcd0};

    assign disp_neg = disp_q[12];
    assign disp_h   = disp_q[11:8];
    assign disp_t   = disp_q[7:4];
    assign disp_o   = disp_q[3:0];

`ifdef SEG7_LZB_EN
    assign blank_h = (disp_h == 4'd0);
    assign blank_t = blank_h && (disp_t == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    // Prescaler and digit index
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tc) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Staging / display buffers; a load on the boundary bypasses staging
    always_comb begin
        stg_d     = stg_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (load) begin
            stg_d     = load_val;
            pending_d = 1'b1;
        end
        if (boundary && (pending_q || load)) begin
            disp_d    = load ? load_val : stg_q;
            pending_d = 1'b0;
        end
    end

    // Output decode from current index and display buffer
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = SegBlank;
        case (idx_q)
            2'd0:    seg_d = digit_code(disp_o);
            2'd1:    seg_d = blank_t ? SegBlank : digit_code(disp_t);
            2'd2:    seg_d = blank_h ? SegBlank : digit_code(disp_h);
            default: seg_d = disp_neg ? SegMinus : SegBlank;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pending_q <= 1'b0;
            stg_q     <= '0;
            disp_q    <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SegBlank;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            stg_q     <= stg_d;
            disp_q    <= disp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= boundary;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CLK_DIV=4 (16-cycle frames).
// Expected segment values follow SEG7_LZB_EN when it is defined.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       neg;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    int checks;
    int failures;
    int k;

`ifdef SEG7_LZB_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    seg7_scan_driver #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .neg   (neg),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .an    (an),
        .seg   (seg),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    task automatic do_load(input logic n, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o);
        load = 1'b1;
        neg  = n;
        bcd2 = h;
        bcd1 = t;
        bcd0 = o;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] an_tab [4];
        logic [6:0] zero_tab [4];
        an_tab   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        zero_tab = '{7'h40, Lzb ? 7'h7F : 7'h40, Lzb ? 7'h7F : 7'h40, 7'h7F};

        checks = 0;
        failures = 0;
        k = 0;
        rst_n = 1'b0;
        load = 1'b0;
        neg = 1'b0;
        bcd2 = 4'd0;
        bcd1 = 4'd0;
        bcd0 = 4'd0;

        #12;
        chk("reset_an", 13'(an), 13'(4'b1111));
        chk("reset_seg", 13'(seg), 13'(7'h7F));
        chk("reset_frame", 13'(frame), 13'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan of the reset (all-zero) value
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("idle_an", 13'(an), 13'(an_tab[(i - 1) / 4]));
            chk("idle_seg", 13'(seg), 13'(zero_tab[(i - 1) / 4]));
            chk("idle_frame", 13'(frame), 13'(i == 16));
        end

        // Mid-frame load of -128: old value held until the boundary
        run_to(20);
        do_load(1'b1, 4'd1, 4'd2, 4'd8);
        run_to(25);
        chk("hold_seg", 13'(seg), 13'(zero_tab[2]));
        run_to(31);
        chk("pre_bnd_frame", 13'(frame), 13'(1'b0));
        run_to(32);
        chk("bnd_frame", 13'(frame), 13'(1'b1));
        chk("bnd_an", 13'(an), 13'(4'b0111));
        chk("bnd_seg_old", 13'(seg), 13'(7'h7F));
        run_to(33);
        chk("post_bnd_frame", 13'(frame), 13'(1'b0));
        chk("m128_an0", 13'(an), 13'(4'b1110));
        chk("m128_ones", 13'(seg), 13'(7'h00));

        // Two loads in one frame: 123 then 045
        do_load(1'b0, 4'd1, 4'd2, 4'd3);
        run_to(37);
        chk("m128_tens", 13'(seg), 13'(7'h24));
        do_load(1'b0, 4'd0, 4'd4, 4'd5);
        run_to(41);
        chk("m128_hund", 13'(seg), 13'(7'h79));
        run_to(45);
        chk("m128_sign_an", 13'(an), 13'(4'b0111));
        chk("m128_sign", 13'(seg), 13'(7'h3F));
        run_to(48);
        chk("f3_frame", 13'(frame), 13'(1'b1));
        run_to(49);
        chk("v045_ones", 13'(seg), 13'(7'h12));
        run_to(53);
        chk("v045_tens", 13'(seg), 13'(7'h19));
        run_to(57);
        chk("v045_hund", 13'(seg), 13'(Lzb ? 7'h7F : 7'h40));
        run_to(61);
        chk("v045_sign", 13'(seg), 13'(7'h7F));

        // Load exactly on the boundary edge (k=64): -907 committed by bypass
        run_to(63);
        do_load(1'b1, 4'd9, 4'd0, 4'd7);
        chk("byp_frame", 13'(frame), 13'(1'b1));
        chk("byp_pending", 13'(dut.pending_q), 13'(1'b0));
        run_to(65);
        chk("byp_ones", 13'(seg), 13'(7'h78));
        run_to(69);
        chk("byp_tens", 13'(seg), 13'(7'h40));
        run_to(73);
        chk("byp_hund", 13'(seg), 13'(7'h10));
        run_to(77);
        chk("byp_sign", 13'(seg), 13'(7'h3F));

        // Out-of-range tens code shows 'E'
        run_to(81);
        do_load(1'b0, 4'd3, 4'hC, 4'd0);
        chk("err_pending", 13'(dut.pending_q), 13'(1'b1));
        run_to(96);
        chk("err_frame", 13'(frame), 13'(1'b1));
        run_to(97);
        chk("err_ones", 13'(seg), 13'(7'h40));
        run_to(101);
        chk("err_tens", 13'(seg), 13'(7'h06));
        run_to(105);
        chk("err_hund", 13'(seg), 13'(7'h30));
        run_to(109);
        chk("err_sign", 13'(seg), 13'(7'h7F));

        // Asynchronous reset with -555 pending
        run_to(110);
        do_load(1'b1, 4'd5, 4'd5, 4'd5);
        run_to(113);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 13'(an), 13'(4'b1111));
        chk("arst_seg", 13'(seg), 13'(7'h7F));
        chk("arst_frame", 13'(frame), 13'(1'b0));
        @(posedge clk);
        #1;
        chk("arst_hold_an", 13'(an), 13'(4'b1111));
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if ((i - 1) % 4 == 0) begin
                chk("post_rst_an", 13'(an), 13'(an_tab[((i - 1) / 4) % 4]));
                chk("post_rst_seg", 13'(seg), 13'(zero_tab[((i - 1) / 4) % 4]));
            end
            if (i == 16) chk("post_rst_frame", 13'(frame), 13'(1'b1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
